sense_push_arbiter: RTL
=======================

Name: sense_push_arbiter

Overview:
- Synchronous controller that starts N Balsa sense producers and shares one clocked valid/ready output among their 4-phase bundled-data push channels (`push_r`/`push_a`/`push_d`).
- Synchronises each incoming push request, grants channels round-robin, returns a 4-phase acknowledge for each granted channel, and counts completed transfers.
- Sits on the boundary between the asynchronous sense instances and the clocked consumer.

Parameters:
- N, 4, number of sense producers; legal range 2..16.
- SYNC_STAGES, 2, flops per request synchroniser; legal range 2..3.
- TIMEOUT, 255, cycles allowed in WAIT_RLO before the timeout error sets.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  in  1  system clock.
- nreset  in  1  asynchronous, active-low reset.
- en  in  N  per-channel enable; a rising edge starts the producer; while low the channel is not granted.
- act_r  out  N  activate request to each sense instance.
- push_r  in  N  push request from each producer (asynchronous).
- push_d  in  N  push data, bundled with push_r.
- push_a  out  N  push acknowledge to each producer.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer ready.
- out_data  out  1  captured push bit.
- out_src  out  $clog2(N)  index of the source channel.
- out_cnt  out  CNT_W  count of completed transfers.
- err_timeout  out  1  sticky timeout error flag.

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, round-robin pointer 0, synchroniser flops 0.
  - System requirement: the sense instances' `initialise` is asserted while nreset is low.
- Activation:
  - act_r[i] sets on the clock edge after en[i] is sampled 0→1.
  - act_r[i] clears only on reset. A Balsa loop never acknowledges, so dropping activate would be a protocol violation.
- Synchronisation:
  - preq = push_r after SYNC_STAGES flops.
  - push_d is not synchronised. It is captured only after preq[i]=1 and while push_a[i]=0; the bundling constraint guarantees it is stable then.
- Eligibility: elig = preq & en & act_r.
- FSM states IDLE, OFFER, ACK_HI, WAIT_RLO, ACK_LO:
  - IDLE: if elig≠0, grant the first set bit searching from ptr upward with wrap. Register src, register data = push_d[src], set out_valid, set ptr = src+1 mod N, go to OFFER. If elig=0, stay.
  - OFFER:
    - out_valid=1, and out_data/out_src are held stable.
    - On out_valid&out_ready: clear out_valid, increment out_cnt (wraps modulo 2^CNT_W), set push_a[src]=1, go to ACK_HI.
  - ACK_HI: unconditional single cycle, then WAIT_RLO; load the timeout counter with 0.
  - WAIT_RLO:
    - Hold push_a[src]=1 until preq[src]=0, then go to ACK_LO.
    - Each cycle, increment the timeout counter. When it reaches TIMEOUT, set err_timeout. Keep waiting; the handshake is never aborted.
  - ACK_LO: clear push_a[src], then go to IDLE. The next grant can be no earlier than the following cycle.
- Only one push_a bit is ever high. push_a never rises before the matching output transfer.
- Latency: push_r rising (setup met) → out_valid=1 after SYNC_STAGES+1 edges; allow +1 edge for metastability.
- Dropping en[src] mid-handshake does not abort: the current handshake completes and only future grants are masked.
- out_ready held low: the FSM stalls in OFFER indefinitely and the producer stalls with it.
- Simultaneous requests: strict round-robin, so no channel waits more than N-1 grants.
- err_timeout clears only on reset.
- Reset mid-handshake: push_a and out_valid drop immediately; the transfer is lost and not counted.

Decomposition:
- Package sense_arb_pkg:
  - state enum typedef (IDLE, OFFER, ACK_HI, WAIT_RLO, ACK_LO);
  - IDX_W = $clog2(N) helper;
  - the round-robin pick function (vector, pointer → index).
- Sub-module sense_sync: N-bit, SYNC_STAGES-deep flop synchroniser with async active-low reset to 0. Instantiated once, for push_r.

Test Plan:
- Reset, then en=4'b0001, push_r[0]↑ with d=1, out_ready=1:
  - act_r=0001 one cycle after en;
  - out_valid within 3–4 edges with out_data=1, out_src=0;
  - push_a[0]↑; push_r[0]↓ → push_a[0]↓; out_cnt=1.
- en=4'b1111, all push_r high with d=1,0,1,0, each dropping when its ack rises and re-rising after ack falls:
  - grant order 0,1,2,3,0;
  - out_data 1,0,1,0,1;
  - out_cnt=5.
- out_ready=0 for 20 cycles during OFFER:
  - out_valid, out_data and out_src stable;
  - push_a stays 0;
  - out_cnt unchanged until ready.
- Producer holds push_r[2] high 300 cycles after ack with TIMEOUT=255:
  - err_timeout=1 at cycle 255 of WAIT_RLO;
  - push_a[2] stays 1 until push_r[2]↓, then the handshake completes normally.
- en[1]↓ while channel 1 is in ACK_HI:
  - the handshake completes;
  - later push_r[1] is ignored;
  - act_r[1] stays 1.
- nreset asserted in WAIT_RLO:
  - push_a, out_valid, out_cnt, act_r and err_timeout read 0 immediately, not waiting for a clock edge.

Source files
------------

// File: rtl/sense_arb_pkg.sv
// Shared types and helpers for the sense push arbiter: FSM state encoding,
// index-width helper and the round-robin grant search.
package sense_arb_pkg;

  typedef enum logic [2:0] {IDLE, OFFER, ACK_HI, WAIT_RLO, ACK_LO} arb_state_e;

  localparam int MAX_N = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of vec at or above ptr, wrapping at n; ptr when vec is empty.
  function automatic int rr_pick(input logic [MAX_N-1:0] vec, input int ptr, input int n);
    int   sel;
    int   idx;
    logic found;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && vec[idx[3:0]]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sense_sync.sv
// W-bit, STAGES-deep flop synchroniser; all stages clear on reset.
module sense_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [STAGES-1:0][W-1:0] sync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sense_push_arbiter.sv
// Starts N Balsa sense producers and funnels their 4-phase push channels onto
// one valid/ready output, granting round-robin and counting completed transfers.
module sense_push_arbiter
  import sense_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [N-1:0]         en,
  output logic [N-1:0]         act_r,
  input  logic [N-1:0]         push_r,
  input  logic [N-1:0]         push_d,
  output logic [N-1:0]         push_a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_data,
  output logic [idx_w(N)-1:0]  out_src,
  output logic [CNT_W-1:0]     out_cnt,
  output logic                 err_timeout
);

  localparam int IDX_W = idx_w(N);
  localparam int TW    = $clog2(TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic             data_q, data_d;
  logic             valid_q, valid_d;
  logic [N-1:0]     pa_q, pa_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [N-1:0]     act_q, en_q;

  logic [N-1:0]     preq;
  logic [N-1:0]     elig;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] pick_nxt;

  sense_sync #(.W(N), .STAGES(SYNC_STAGES)) u_req_sync (
    .clk    (clk),
    .nreset (nreset),
    .d_i    (push_r),
    .q_o    (preq)
  );

  // Activate is one-way: a Balsa loop never acknowledges it, so it only clears on reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      act_q <= '0;
      en_q  <= '0;
    end else begin
      act_q <= act_q | (en & ~en_q);
      en_q  <= en;
    end
  end

  assign elig     = preq & en & act_q;
  assign pick     = IDX_W'(rr_pick(MAX_N'(elig), int'(ptr_q), N));
  assign pick_nxt = (pick == IDX_W'(N - 1)) ? '0 : pick + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    data_d  = data_q;
    valid_d = valid_q;
    pa_d    = pa_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        // push_d is safe to sample here: preq is high and push_a is still low.
        if (|elig) begin
          src_d   = pick;
          data_d  = push_d[pick];
          valid_d = 1'b1;
          ptr_d   = pick_nxt;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          pa_d    = N'(1) << src_q;
          state_d = ACK_HI;
        end
      end
      ACK_HI: begin
        tcnt_d  = '0;
        state_d = WAIT_RLO;
      end
      WAIT_RLO: begin
        if (tcnt_q != TW'(TIMEOUT)) begin
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_q == TW'(TIMEOUT - 1)) err_d = 1'b1;
        end
        if (!preq[src_q]) begin
          pa_d    = '0;
          state_d = ACK_LO;
        end
      end
      ACK_LO:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      pa_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pa_q    <= pa_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign act_r       = act_q;
  assign push_a      = pa_q;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_src     = src_q;
  assign out_cnt     = cnt_q;
  assign err_timeout = err_q;

endmodule
